// File: rtl/button_event_controller_if.sv
// button_event_controller_if: raw button levels in, debounced levels, event pulses and mode index out.
interface button_event_controller_if #(
    parameter int NUM_BUTTONS = 7,
    parameter int MODE_W      = 2
);
    logic [NUM_BUTTONS-1:0] pButton;
    logic [NUM_BUTTONS-1:0] vLevel;
    logic [NUM_BUTTONS-1:0] vPress;
    logic [NUM_BUTTONS-1:0] vRelease;
    logic [NUM_BUTTONS-1:0] vLong;
    logic [NUM_BUTTONS-1:0] vRepeat;
    logic [MODE_W-1:0]      clk_mode;
    modport master (output pButton, input vLevel, vPress, vRelease, vLong, vRepeat, clk_mode);
    modport slave  (input pButton, output vLevel, vPress, vRelease, vLong, vRepeat, clk_mode);
endinterface

// File: rtl/button_event_controller.sv
// button_event_controller: per-channel sync/debounce with press, release, long and repeat events, plus a mode counter.
module button_event_controller #(
    parameter int                     NUM_BUTTONS     = 7,
    parameter int                     DEBOUNCE_CYCLES = 20000,
    parameter int                     LONG_CYCLES     = 2000000,
    parameter int                     REPEAT_CYCLES   = 200000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = '1,
    parameter int                     MODE_BTN        = 0,
    parameter int                     NUM_MODES       = 3,
    parameter int                     MODE_W          = 2
) (
    input logic                      mclk,
    input logic                      rst,
    button_event_controller_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES);
    typedef enum logic [1:0] {IDLE, HELD, LONG} hold_e;
    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
    logic [NUM_BUTTONS-1:0] long_q, long_d, repeat_q, repeat_d;
    logic [NUM_BUTTONS-1:0] flip, long_hit, rep_hit;
    logic [DW-1:0]          deb_q   [NUM_BUTTONS];
    logic [DW-1:0]          deb_d   [NUM_BUTTONS];
    logic [HW-1:0]          hold_q  [NUM_BUTTONS];
    logic [HW-1:0]          hold_d  [NUM_BUTTONS];
    hold_e                  state_q [NUM_BUTTONS];
    hold_e                  state_d [NUM_BUTTONS];
    logic [MODE_W-1:0]      mode_q, mode_d;
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            flip[i]      = (sync2_q[i] != level_q[i]) && (deb_q[i] == DW'(DEBOUNCE_CYCLES - 1));
            deb_d[i]     = (sync2_q[i] == level_q[i] || flip[i]) ? '0 : deb_q[i] + 1'b1;
            level_d[i]   = flip[i] ? sync2_q[i] : level_q[i];
            press_d[i]   = flip[i] & sync2_q[i];
            release_d[i] = flip[i] & ~sync2_q[i];
            long_hit[i]  = (state_q[i] == HELD) && (hold_q[i] == HW'(LONG_CYCLES - 1));
            rep_hit[i]   = (state_q[i] == LONG) && REPEAT_MASK[i] && (hold_q[i] == HW'(REPEAT_CYCLES - 1));
            // A release landing on a terminal count wins and swallows the pulse
            long_d[i]    = long_hit[i] & ~release_d[i];
            repeat_d[i]  = rep_hit[i] & ~release_d[i];
            state_d[i]   = release_d[i] ? IDLE : press_d[i] ? HELD : long_hit[i] ? LONG : state_q[i];
            hold_d[i]    = (release_d[i] | press_d[i] | long_hit[i] | rep_hit[i]) ? '0 :
                           (state_q[i] == HELD || (state_q[i] == LONG && REPEAT_MASK[i])) ? hold_q[i] + 1'b1 : '0;
        end
        mode_d = !press_d[MODE_BTN] ? mode_q : (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
    end
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            mode_q    <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_q[i]   <= '0;
                hold_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q   <= bus.pButton;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            mode_q    <= mode_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_q[i]   <= deb_d[i];
                hold_q[i]  <= hold_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end
    assign bus.vLevel   = level_q;
    assign bus.vPress   = press_q;
    assign bus.vRelease = release_q;
    assign bus.vLong    = long_q;
    assign bus.vRepeat  = repeat_q;
    assign bus.clk_mode = mode_q;
endmodule

// File: tb/tb_button_event_controller.sv
// tb_button_event_controller: directed scenarios plus random button traffic against a hold-time reference model.
module tb_button_event_controller;
    localparam int             NB   = 3;
    localparam int             DEB  = 4;
    localparam int             LNG  = 10;
    localparam int             REP  = 3;
    localparam logic [NB-1:0]  MASK = 3'b101;
    localparam int             MB   = 0;
    localparam int             NM   = 3;
    localparam int             MW   = 2;

    logic mclk = 1'b0;
    logic rst  = 1'b0;
    always #5 mclk = ~mclk;

    button_event_controller_if #(.NUM_BUTTONS(NB), .MODE_W(MW)) bus ();

    button_event_controller #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP),
        .REPEAT_MASK(MASK), .MODE_BTN(MB), .NUM_MODES(NM), .MODE_W(MW)
    ) dut (
        .mclk(mclk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: input pipeline, run length of disagreeing samples, cycles held since press
    logic [NB-1:0] m_p1, m_p2, m_lvl, m_press, m_rel, m_long, m_rep;
    int            m_run  [NB];
    int            m_held [NB];
    int            m_mode;
    int            cnt_press [NB];
    int            cnt_rel   [NB];
    int            cnt_long  [NB];
    int            cnt_rep   [NB];
    int            dur       [NB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_lvl = '0;
        m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        m_mode = 0;
        for (int i = 0; i < NB; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [NB-1:0] s;
        s = m_p2;
        for (int i = 0; i < NB; i++) begin
            logic flip;
            flip = 1'b0;
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    flip     = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_press[i] = flip & s[i];
            m_rel[i]   = flip & ~s[i];
            m_long[i]  = 1'b0;
            m_rep[i]   = 1'b0;
            if (m_lvl[i] && !m_rel[i]) begin
                m_held[i]++;
                m_long[i] = (m_held[i] == LNG);
                m_rep[i]  = MASK[i] && (m_held[i] > LNG) && ((m_held[i] - LNG) % REP == 0);
            end
            if (m_press[i]) m_held[i] = 0;
            if (flip) m_lvl[i] = s[i];
        end
        if (m_press[MB]) m_mode = (m_mode + 1) % NM;
        m_p2 = m_p1;
        m_p1 = bus.pButton;
    endtask

    task automatic compare();
        check("vLevel",   bus.vLevel,   m_lvl);
        check("vPress",   bus.vPress,   m_press);
        check("vRelease", bus.vRelease, m_rel);
        check("vLong",    bus.vLong,    m_long);
        check("vRepeat",  bus.vRepeat,  m_rep);
        check("clk_mode", bus.clk_mode, m_mode);
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] += int'(bus.vPress[i]);
            cnt_rel[i]   += int'(bus.vRelease[i]);
            cnt_long[i]  += int'(bus.vLong[i]);
            cnt_rep[i]   += int'(bus.vRepeat[i]);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0; cnt_rep[i] = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            if (rst) model_step();
            @(negedge mclk);
            compare();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, bus.vLevel,   '0);
        check({tag, "_press"}, bus.vPress,   '0);
        check({tag, "_rel"},   bus.vRelease, '0);
        check({tag, "_long"},  bus.vLong,    '0);
        check({tag, "_rep"},   bus.vRepeat,  '0);
        check({tag, "_mode"},  bus.clk_mode, '0);
    endtask

    initial begin
        int mode_seq [4];
        mode_seq = '{1, 2, 0, 1};
        bus.pButton = '0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge mclk);
        check_all_zero("reset");
        rst = 1'b1;
        tick(3);

        // Clean press/release latency on channel 1
        bus.pButton[1] = 1'b1;
        tick(5);
        check("press1_early", bus.vPress[1], 1'b0);
        tick(1);
        check("press1_lat", bus.vPress[1], 1'b1);
        check("level1_up", bus.vLevel[1], 1'b1);
        tick(1);
        check("press1_once", bus.vPress[1], 1'b0);
        tick(4);
        bus.pButton[1] = 1'b0;
        tick(5);
        check("rel1_early", bus.vRelease[1], 1'b0);
        tick(1);
        check("rel1_lat", bus.vRelease[1], 1'b1);
        check("level1_down", bus.vLevel[1], 1'b0);
        tick(6);

        // Glitch and bounce on channel 2, then a steady long hold
        clear_counts();
        bus.pButton[2] = 1'b1; tick(3);
        bus.pButton[2] = 1'b0; tick(3);
        for (int k = 0; k < 10; k++) begin
            bus.pButton[2] = ~bus.pButton[2];
            tick(2);
        end
        tick(6);
        check("bounce_press", cnt_press[2], 0);
        check("bounce_level", bus.vLevel[2], 1'b0);
        bus.pButton[2] = 1'b1;
        tick(8);
        check("steady_press", cnt_press[2], 1);
        tick(30);
        check("hold2_long", cnt_long[2], 1);
        check("hold2_rep", cnt_rep[2], 7);
        bus.pButton[2] = 1'b0;
        tick(8);

        // Channel 1 is masked from auto-repeat
        clear_counts();
        bus.pButton[1] = 1'b1;
        tick(36);
        check("hold1_long", cnt_long[1], 1);
        check("hold1_rep", cnt_rep[1], 0);
        bus.pButton[1] = 1'b0;
        tick(8);

        // Mode stepping and a long hold on the mode button
        for (int k = 0; k < 4; k++) begin
            bus.pButton[0] = 1'b1;
            tick(8);
            check("mode_step", bus.clk_mode, mode_seq[k]);
            bus.pButton[0] = 1'b0;
            tick(8);
        end
        clear_counts();
        bus.pButton[0] = 1'b1;
        tick(25);
        check("mode_long_evt", cnt_long[0], 1);
        check("mode_after_long", bus.clk_mode, 2);
        bus.pButton[0] = 1'b0;
        tick(8);
        check("mode_after_rel", bus.clk_mode, 2);

        // Reset while channel 0 sits in LONG, then release with the button still down
        bus.pButton[0] = 1'b1;
        tick(20);
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("midrst");
        @(negedge mclk);
        tick(2);
        rst = 1'b1;
        tick(5);
        check("rst_press_early", bus.vPress[0], 1'b0);
        tick(1);
        check("rst_press", bus.vPress[0], 1'b1);
        check("rst_mode", bus.clk_mode, 1);
        bus.pButton[0] = 1'b0;
        tick(8);

        // All channels together, release landing on the long terminal count
        clear_counts();
        bus.pButton = '1;
        tick(6);
        check("all_press", bus.vPress, 3'b111);
        tick(4);
        bus.pButton = '0;
        tick(10);
        for (int i = 0; i < NB; i++) begin
            check("race_long", cnt_long[i], 0);
            check("race_rel", cnt_rel[i], 1);
        end

        // Random traffic with mixed short glitches and long holds
        for (int i = 0; i < NB; i++) dur[i] = $urandom_range(1, 16);
        repeat (800) begin
            for (int i = 0; i < NB; i++) begin
                if (dur[i] == 0) begin
                    bus.pButton[i] = ~bus.pButton[i];
                    dur[i] = $urandom_range(1, 20);
                end else begin
                    dur[i]--;
                end
            end
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
